// File: rtl/collision_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : collision_frame_scheduler
// Description : Latches per-ball collision/hole events during a frame and
//               commits one velocity load / sink event per ball at the next
//               startOfFrame, with a per-ball post-collision cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_frame_scheduler #(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int CNT_W           = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               newRack,
  input  logic               whiteCol,
  input  logic signed [10:0] whiteVelXIn,
  input  logic signed [10:0] whiteVelYIn,
  input  logic               whiteHoleHit,
  input  logic        [2:0]  whiteHoleNum,
  input  logic               redCol,
  input  logic signed [10:0] redVelXIn,
  input  logic signed [10:0] redVelYIn,
  input  logic               redHoleHit,
  input  logic        [2:0]  redHoleNum,
  output logic               whiteVelLoad,
  output logic signed [10:0] whiteVelXOut,
  output logic signed [10:0] whiteVelYOut,
  output logic               redVelLoad,
  output logic signed [10:0] redVelXOut,
  output logic signed [10:0] redVelYOut,
  output logic               whiteSunk,
  output logic               redSunk,
  output logic               sinkEvent,
  output logic        [2:0]  sinkHoleNum,
  output logic               sinkIsWhite
);

  localparam logic [CNT_W-1:0] c_cd_load = CNT_W'(COOLDOWN_FRAMES);

  // Index 0 = white ball, index 1 = red ball
  logic               w_col      [2];
  logic signed [10:0] w_vx_in    [2];
  logic signed [10:0] w_vy_in    [2];
  logic               w_hole_hit [2];
  logic        [2:0]  w_hole_in  [2];
  logic               w_load     [2];
  logic signed [10:0] w_vx_out   [2];
  logic signed [10:0] w_vy_out   [2];
  logic               w_sunk     [2];
  logic               w_sink     [2];
  logic        [2:0]  w_hole_num [2];

  assign w_col[0]      = whiteCol;
  assign w_col[1]      = redCol;
  assign w_vx_in[0]    = whiteVelXIn;
  assign w_vx_in[1]    = redVelXIn;
  assign w_vy_in[0]    = whiteVelYIn;
  assign w_vy_in[1]    = redVelYIn;
  assign w_hole_hit[0] = whiteHoleHit;
  assign w_hole_hit[1] = redHoleHit;
  assign w_hole_in[0]  = whiteHoleNum;
  assign w_hole_in[1]  = redHoleNum;

  for (genvar b = 0; b < 2; b++) begin : g_ball
    logic               r_col_pend;
    logic               r_hole_pend;
    logic               r_sunk;
    logic               r_load;
    logic signed [10:0] r_vx;
    logic signed [10:0] r_vy;
    logic signed [10:0] r_vx_out;
    logic signed [10:0] r_vy_out;
    logic        [2:0]  r_hole;
    logic [CNT_W-1:0]   r_cd;
    logic               w_sink_now;
    logic               w_post_sunk;
    logic [CNT_W-1:0]   w_post_cd;
    logic               w_col_ok;
    logic               w_hole_ok;

    // Events coincident with a commit are judged against post-commit state
    always_comb begin
      w_sink_now  = startOfFrame & r_hole_pend;
      w_post_sunk = r_sunk | w_sink_now;
      w_post_cd   = r_cd;
      if (startOfFrame && !w_sink_now) begin
        if (r_col_pend)
          w_post_cd = c_cd_load;
        else if (r_cd != '0)
          w_post_cd = r_cd - CNT_W'(1);
      end
      w_col_ok  = w_col[b] & ~w_post_sunk & (w_post_cd == '0) & (startOfFrame | ~r_col_pend);
      w_hole_ok = w_hole_hit[b] & ~w_post_sunk & (startOfFrame | ~r_hole_pend);
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_col_pend  <= 1'b0;
        r_hole_pend <= 1'b0;
        r_sunk      <= 1'b0;
        r_load      <= 1'b0;
        r_vx        <= '0;
        r_vy        <= '0;
        r_vx_out    <= '0;
        r_vy_out    <= '0;
        r_hole      <= '0;
        r_cd        <= '0;
      end else if (newRack) begin
        r_col_pend  <= 1'b0;
        r_hole_pend <= 1'b0;
        r_sunk      <= 1'b0;
        r_load      <= 1'b0;
        r_cd        <= '0;
      end else begin
        r_load <= 1'b0;
        if (startOfFrame) begin
          r_col_pend  <= 1'b0;
          r_hole_pend <= 1'b0;
          r_cd        <= w_post_cd;
          r_sunk      <= w_post_sunk;
          if (w_sink_now) begin
            r_load   <= 1'b1;
            r_vx_out <= '0;
            r_vy_out <= '0;
          end else if (r_col_pend) begin
            r_load   <= 1'b1;
            r_vx_out <= r_vx;
            r_vy_out <= r_vy;
          end
        end
        if (w_col_ok) begin
          r_col_pend <= 1'b1;
          r_vx       <= w_vx_in[b];
          r_vy       <= w_vy_in[b];
        end
        if (w_hole_ok) begin
          r_hole_pend <= 1'b1;
          r_hole      <= w_hole_in[b];
        end
      end
    end

    assign w_load[b]     = r_load;
    assign w_vx_out[b]   = r_vx_out;
    assign w_vy_out[b]   = r_vy_out;
    assign w_sunk[b]     = r_sunk;
    assign w_sink[b]     = w_sink_now;
    assign w_hole_num[b] = r_hole;
  end

  logic       r_sink_ev;
  logic [2:0] r_sink_hole;
  logic       r_sink_white;

  // White takes the reported hole when both balls sink at the same commit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sink_ev    <= 1'b0;
      r_sink_hole  <= '0;
      r_sink_white <= 1'b0;
    end else if (newRack) begin
      r_sink_ev <= 1'b0;
    end else begin
      r_sink_ev <= w_sink[0] | w_sink[1];
      if (w_sink[0]) begin
        r_sink_hole  <= w_hole_num[0];
        r_sink_white <= 1'b1;
      end else if (w_sink[1]) begin
        r_sink_hole  <= w_hole_num[1];
        r_sink_white <= 1'b0;
      end
    end
  end

  assign whiteVelLoad = w_load[0];
  assign whiteVelXOut = w_vx_out[0];
  assign whiteVelYOut = w_vy_out[0];
  assign redVelLoad   = w_load[1];
  assign redVelXOut   = w_vx_out[1];
  assign redVelYOut   = w_vy_out[1];
  assign whiteSunk    = w_sunk[0];
  assign redSunk      = w_sunk[1];
  assign sinkEvent    = r_sink_ev;
  assign sinkHoleNum  = r_sink_hole;
  assign sinkIsWhite  = r_sink_white;

endmodule
`default_nettype wire

// File: tb/tb_collision_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_frame_scheduler
// Description : Scoreboard bench for collision_frame_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_frame_scheduler;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame, newRack;
  logic               whiteCol, whiteHoleHit, redCol, redHoleHit;
  logic signed [10:0] whiteVelXIn, whiteVelYIn, redVelXIn, redVelYIn;
  logic        [2:0]  whiteHoleNum, redHoleNum;
  logic               whiteVelLoad, redVelLoad, whiteSunk, redSunk;
  logic               sinkEvent, sinkIsWhite;
  logic signed [10:0] whiteVelXOut, whiteVelYOut, redVelXOut, redVelYOut;
  logic        [2:0]  sinkHoleNum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic               wl;
    logic signed [10:0] wx;
    logic signed [10:0] wy;
    logic               rl;
    logic signed [10:0] rx;
    logic signed [10:0] ry;
    logic               se;
    logic               sw;
    logic        [2:0]  sh;
  } ev_t;

  ev_t   exp_q  [$];
  string name_q [$];

  collision_frame_scheduler #(.COOLDOWN_FRAMES(4), .CNT_W(3)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newRack(newRack),
    .whiteCol(whiteCol), .whiteVelXIn(whiteVelXIn), .whiteVelYIn(whiteVelYIn),
    .whiteHoleHit(whiteHoleHit), .whiteHoleNum(whiteHoleNum),
    .redCol(redCol), .redVelXIn(redVelXIn), .redVelYIn(redVelYIn),
    .redHoleHit(redHoleHit), .redHoleNum(redHoleNum),
    .whiteVelLoad(whiteVelLoad), .whiteVelXOut(whiteVelXOut), .whiteVelYOut(whiteVelYOut),
    .redVelLoad(redVelLoad), .redVelXOut(redVelXOut), .redVelYOut(redVelYOut),
    .whiteSunk(whiteSunk), .redSunk(redSunk),
    .sinkEvent(sinkEvent), .sinkHoleNum(sinkHoleNum), .sinkIsWhite(sinkIsWhite)
  );

  always #5 clk = ~clk;

  // Fields that carry no meaning for a record are zeroed before comparing
  function automatic ev_t mask(ev_t e);
    ev_t m;
    m = e;
    if (!m.wl) begin m.wx = '0; m.wy = '0; end
    if (!m.rl) begin m.rx = '0; m.ry = '0; end
    if (!m.se) begin m.sw = 1'b0; m.sh = '0; end
    return m;
  endfunction

  always @(negedge clk) begin
    if (resetN === 1'b1 && (whiteVelLoad | redVelLoad | sinkEvent)) begin
      ev_t   obs;
      ev_t   e;
      string n;
      obs = mask({whiteVelLoad, whiteVelXOut, whiteVelYOut, redVelLoad, redVelXOut,
                  redVelYOut, sinkEvent, sinkIsWhite, sinkHoleNum});
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got wl=%0b wv=(%0d,%0d) rl=%0b rv=(%0d,%0d) se=%0b sw=%0b sh=%0d, required none",
                 obs.wl, obs.wx, obs.wy, obs.rl, obs.rx, obs.ry, obs.se, obs.sw, obs.sh);
      end else begin
        e = mask(exp_q.pop_front());
        n = name_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s: got wl=%0b wv=(%0d,%0d) rl=%0b rv=(%0d,%0d) se=%0b sw=%0b sh=%0d, required wl=%0b wv=(%0d,%0d) rl=%0b rv=(%0d,%0d) se=%0b sw=%0b sh=%0d",
                   n, obs.wl, obs.wx, obs.wy, obs.rl, obs.rx, obs.ry, obs.se, obs.sw, obs.sh,
                   e.wl, e.wx, e.wy, e.rl, e.rx, e.ry, e.se, e.sw, e.sh);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic chk(string n, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", n, got, want);
    end
  endtask

  task automatic expect_ev(string n, logic wl, int wx, int wy, logic rl, int rx, int ry,
                           logic se, logic sw, int sh);
    ev_t e;
    e.wl = wl; e.wx = 11'(wx); e.wy = 11'(wy);
    e.rl = rl; e.rx = 11'(rx); e.ry = 11'(ry);
    e.se = se; e.sw = sw;      e.sh = 3'(sh);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    idle(2);
  endtask

  task automatic rack();
    newRack = 1'b1;
    tick();
    newRack = 1'b0;
    tick();
  endtask

  task automatic wcol(int x, int y);
    whiteCol = 1'b1; whiteVelXIn = 11'(x); whiteVelYIn = 11'(y);
    tick();
    whiteCol = 1'b0;
    tick();
  endtask

  task automatic rcol(int x, int y);
    redCol = 1'b1; redVelXIn = 11'(x); redVelYIn = 11'(y);
    tick();
    redCol = 1'b0;
    tick();
  endtask

  task automatic whole(int h);
    whiteHoleHit = 1'b1; whiteHoleNum = 3'(h);
    tick();
    whiteHoleHit = 1'b0;
    tick();
  endtask

  task automatic rhole(int h);
    redHoleHit = 1'b1; redHoleNum = 3'(h);
    tick();
    redHoleHit = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(string n);
    chk({n, "_wl"}, int'(whiteVelLoad), 0);
    chk({n, "_wx"}, int'(whiteVelXOut), 0);
    chk({n, "_wy"}, int'(whiteVelYOut), 0);
    chk({n, "_rl"}, int'(redVelLoad), 0);
    chk({n, "_sunk"}, int'({whiteSunk, redSunk}), 0);
    chk({n, "_sink"}, int'({sinkEvent, sinkIsWhite, sinkHoleNum}), 0);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; newRack = 1'b0;
    whiteCol = 1'b0; whiteHoleHit = 1'b0; redCol = 1'b0; redHoleHit = 1'b0;
    whiteVelXIn = '0; whiteVelYIn = '0; redVelXIn = '0; redVelYIn = '0;
    whiteHoleNum = '0; redHoleNum = '0;
    idle(3);
    chk_all_zero("reset");
    resetN = 1'b1;
    idle(2);

    // Single collision commits at next frame boundary
    wcol(5, -3);
    idle(3);
    expect_ev("white_single", 1, 5, -3, 0, 0, 0, 0, 0, 0);
    sof();
    chk("white_hold_x", int'(whiteVelXOut), 5);
    chk("white_hold_y", int'(whiteVelYOut), -3);
    rack();

    // First strobe of a frame wins
    wcol(5, -3);
    wcol(7, 7);
    expect_ev("white_first_wins", 1, 5, -3, 0, 0, 0, 0, 0, 0);
    sof();
    rack();

    // newRack coincident with a commit suppresses the load
    wcol(1, 1);
    startOfFrame = 1'b1; newRack = 1'b1;
    tick();
    startOfFrame = 1'b0; newRack = 1'b0;
    idle(2);

    // Cooldown: loads at commits 0 and 5 only
    wcol(9, 1);
    expect_ev("cooldown_c0", 1, 9, 1, 0, 0, 0, 0, 0, 0);
    startOfFrame = 1'b1; whiteCol = 1'b1; whiteVelXIn = 11'(6); whiteVelYIn = 11'(6);
    tick();
    startOfFrame = 1'b0; whiteCol = 1'b0;
    idle(2);
    for (int k = 1; k <= 5; k++) begin
      wcol(10 + k, k);
      if (k == 5) expect_ev("cooldown_c5", 1, 15, 5, 0, 0, 0, 0, 0, 0);
      sof();
    end
    rack();

    // Red hole beats red collision in the same frame
    rcol(2, 2);
    rhole(3);
    expect_ev("red_sink", 0, 0, 0, 1, 0, 0, 1, 0, 3);
    sof();
    chk("red_sunk", int'(redSunk), 1);
    chk("white_not_sunk", int'(whiteSunk), 0);
    rcol(4, 4);
    sof();
    chk("red_sunk_no_load_x", int'(redVelXOut), 0);
    rack();

    // Both balls sink at one commit
    whole(1);
    rhole(4);
    expect_ev("both_sink", 1, 0, 0, 1, 0, 0, 1, 1, 1);
    sof();
    chk("both_sunk", int'({whiteSunk, redSunk}), 3);
    rack();
    chk("rack_clears_sunk", int'({whiteSunk, redSunk}), 0);
    wcol(8, -8);
    expect_ev("white_after_rack", 1, 8, -8, 0, 0, 0, 0, 0, 0);
    sof();
    rack();

    // Async reset discards pending collision
    wcol(3, 3);
    #2 resetN = 1'b0;
    #1;
    chk_all_zero("midframe_reset");
    tick();
    resetN = 1'b1;
    tick();
    sof();
    chk("reset_no_load", int'(whiteVelXOut), 0);

    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
